// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states and the
// stall-vector encodings driven onto the six pipeline stages.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_MC_DONE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  // Bit order: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MC       = 6'b001111;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard detector: flags a decode operand that depends on a load
// still in execute. Register 0 is hardwired and never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  output logic                  hazard_o
);

  logic ex_load_dest;
  logic reg1_dep;
  logic reg2_dep;

  assign ex_load_dest = ex_is_load_i & ex_wreg_i & (ex_wd_i != '0);
  assign reg1_dep     = id_reg1_read_i & (id_reg1_addr_i == ex_wd_i);
  assign reg2_dep     = id_reg2_read_i & (id_reg2_addr_i == ex_wd_i);
  assign hazard_o     = ex_load_dest & (reg1_dep | reg2_dep);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: stall vector, multi-cycle execute sequencing,
// registered flush/redirect and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0]  id_reg1_addr_i,
  input  logic                   id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0]  id_reg2_addr_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_wreg_i,
  input  logic [REG_ADDR_W-1:0]  ex_wd_i,
  input  logic                   ex_mc_start_i,
  input  logic [MC_CNT_W-1:0]    ex_mc_cycles_i,
  input  logic                   flush_req_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  input  logic                   perf_clr_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic                   ex_mc_busy_o,
  output logic                   ex_mc_done_o,
  output logic [PERF_W-1:0]      stall_cycles_o
);

  state_e                 state_q, state_d;
  logic [MC_CNT_W-1:0]    cnt_q, cnt_d;
  logic [INST_ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [PERF_W-1:0]      perf_q, perf_d;
  logic                   load_use;

  load_use_detect u_load_use (
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .hazard_o       (load_use)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_o      = STALL_NONE;
    ex_mc_busy_o = 1'b0;
    ex_mc_done_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_mc_start_i) begin
          stall_o = STALL_MC;
          if (ex_mc_cycles_i <= MC_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_MC_DONE;
          end else begin
            cnt_d   = ex_mc_cycles_i - MC_CNT_W'(1);
            state_d = ST_MC_BUSY;
          end
        end else if (load_use) begin
          stall_o = STALL_LOAD_USE;
        end
      end
      ST_MC_BUSY: begin
        stall_o      = STALL_MC;
        ex_mc_busy_o = 1'b1;
        cnt_d        = cnt_q - MC_CNT_W'(1);
        if (cnt_q == MC_CNT_W'(1)) state_d = ST_MC_DONE;
      end
      ST_MC_DONE: begin
        // Execute is released here; a new start is only accepted from IDLE.
        ex_mc_done_o = 1'b1;
        if (load_use) stall_o = STALL_LOAD_USE;
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush overrides everything, including an operation in flight.
    if (flush_req_i) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end
  end

  assign new_pc_d = flush_req_i ? flush_pc_i : new_pc_q;

  always_comb begin
    perf_d = perf_q;
    if (perf_clr_i)                       perf_d = '0;
    else if (stall_o[0] && perf_q != '1)  perf_d = perf_q + PERF_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      perf_q   <= perf_d;
    end
  end

  assign flush_o        = (state_q == ST_FLUSH);
  assign new_pc_o       = new_pc_q;
  assign stall_cycles_o = perf_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: load-use vector table, hand-written
// multi-cycle/flush/reset/counter sequences, then randomized traffic vs a model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int MC_CNT_W = 6;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   id_reg1_read_i, id_reg2_read_i;
  logic [4:0]             id_reg1_addr_i, id_reg2_addr_i;
  logic                   ex_is_load_i, ex_wreg_i;
  logic [4:0]             ex_wd_i;
  logic                   ex_mc_start_i;
  logic [MC_CNT_W-1:0]    ex_mc_cycles_i;
  logic                   flush_req_i;
  logic [31:0]            flush_pc_i;
  logic                   perf_clr_i;
  logic [5:0]             stall_o;
  logic                   flush_o;
  logic [31:0]            new_pc_o;
  logic                   ex_mc_busy_o, ex_mc_done_o;
  logic [PERF_W-1:0]      stall_cycles_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.MC_CNT_W(MC_CNT_W), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_cycles_i (ex_mc_cycles_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .perf_clr_i     (perf_clr_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .ex_mc_busy_o   (ex_mc_busy_o),
    .ex_mc_done_o   (ex_mc_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall cycles of the current operation plus
  // pending done/flush flags; no notion of the RTL's state encoding.
  int          m_busy_left;
  bit          m_done;
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_perf;
  logic [5:0]  m_stall;

  function automatic bit hazard();
    return ex_is_load_i && ex_wreg_i && ex_wd_i != 0 &&
           ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
            (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
  endfunction

  function automatic logic [5:0] model_stall();
    if (m_flush)              return 6'b000000;
    if (m_busy_left > 0)      return 6'b001111;
    if (m_done)               return hazard() ? 6'b000111 : 6'b000000;
    if (ex_mc_start_i)        return 6'b001111;
    return hazard() ? 6'b000111 : 6'b000000;
  endfunction

  task automatic model_reset();
    m_busy_left = 0; m_done = 0; m_flush = 0; m_pc = '0; m_perf = 0;
  endtask

  task automatic model_update();
    m_stall = model_stall();
    if (perf_clr_i)                          m_perf = 0;
    else if (m_stall[0] && m_perf < PERF_MAX) m_perf++;
    if (flush_req_i) begin
      m_flush = 1; m_pc = flush_pc_i; m_busy_left = 0; m_done = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (ex_mc_start_i) begin
      int n;
      n = (ex_mc_cycles_i == 0) ? 1 : int'(ex_mc_cycles_i);
      m_busy_left = n - 1;
      m_done = (n == 1);
    end
  endtask

  task automatic compare_model();
    check("model_stall", stall_o, model_stall());
    check("model_flush", flush_o, m_flush);
    check("model_busy", ex_mc_busy_o, m_busy_left > 0);
    check("model_done", ex_mc_done_o, m_done);
    check("model_perf", stall_cycles_o, m_perf);
    if (m_flush) check("model_new_pc", new_pc_o, m_pc);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    settle();
    compare_model();
    advance();
  endtask

  task automatic clear_inputs();
    id_reg1_read_i = 0; id_reg1_addr_i = 0; id_reg2_read_i = 0; id_reg2_addr_i = 0;
    ex_is_load_i = 0; ex_wreg_i = 0; ex_wd_i = 0;
    ex_mc_start_i = 0; ex_mc_cycles_i = 0;
    flush_req_i = 0; flush_pc_i = 0; perf_clr_i = 0;
  endtask

  task automatic clear_perf();
    perf_clr_i = 1; cycle(); perf_clr_i = 0;
  endtask

  task automatic run_mc(input int n);
    int ns;
    logic [31:0] p0;
    ns = (n == 0) ? 1 : n;
    ex_mc_start_i = 1; ex_mc_cycles_i = MC_CNT_W'(n);
    for (int k = 0; k < ns; k++) begin
      settle();
      if (k == 0) p0 = 32'(stall_cycles_o);
      check($sformatf("mc%0d_stall_t%0d", n, k), stall_o, 6'b001111);
      check($sformatf("mc%0d_nodone_t%0d", n, k), ex_mc_done_o, 0);
      compare_model();
      advance();
    end
    settle();
    check($sformatf("mc%0d_done", n), ex_mc_done_o, 1);
    check($sformatf("mc%0d_released", n), stall_o, 6'b000000);
    check($sformatf("mc%0d_perf_delta", n), 32'(stall_cycles_o), p0 + 32'(ns));
    compare_model();
    advance();
    ex_mc_start_i = 0;
    settle();
    check($sformatf("mc%0d_done_once", n), ex_mc_done_o, 0);
    compare_model();
    advance();
  endtask

  typedef struct {
    logic       r1;
    logic [4:0] a1;
    logic       r2;
    logic [4:0] a2;
    logic       ld;
    logic       wr;
    logic [4:0] wd;
    logic [5:0] exp_stall;
  } lu_vec_t;

  lu_vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b1, 5'd5,  6'b000111};
    vecs[1] = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b1, 5'd0,  6'b000000};
    vecs[2] = '{1'b0, 5'd5,  1'b0, 5'd9,  1'b1, 1'b1, 5'd5,  6'b000000};
    vecs[3] = '{1'b0, 5'd1,  1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  6'b000111};
    vecs[4] = '{1'b1, 5'd5,  1'b1, 5'd5,  1'b0, 1'b1, 5'd5,  6'b000000};
    vecs[5] = '{1'b1, 5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd5,  6'b000000};
    vecs[6] = '{1'b1, 5'd3,  1'b1, 5'd6,  1'b1, 1'b1, 5'd4,  6'b000000};
    vecs[7] = '{1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd31, 6'b000111};

    clear_inputs();
    model_reset();
    rst = 1;
    #1;
    check("reset_stall", stall_o, 0);
    check("reset_flush", flush_o, 0);
    check("reset_new_pc", new_pc_o, 0);
    check("reset_busy", ex_mc_busy_o, 0);
    check("reset_done", ex_mc_done_o, 0);
    check("reset_perf", stall_cycles_o, 0);
    @(posedge clk);
    #1 rst = 0;

    // Load-use table, applied in IDLE.
    foreach (vecs[i]) begin
      id_reg1_read_i = vecs[i].r1; id_reg1_addr_i = vecs[i].a1;
      id_reg2_read_i = vecs[i].r2; id_reg2_addr_i = vecs[i].a2;
      ex_is_load_i = vecs[i].ld; ex_wreg_i = vecs[i].wr; ex_wd_i = vecs[i].wd;
      settle();
      check($sformatf("lu_vec%0d", i), stall_o, vecs[i].exp_stall);
      compare_model();
      advance();
    end
    clear_inputs();

    // Multi-cycle lengths, including the 0 and 1 boundary.
    clear_perf();
    run_mc(3);
    run_mc(0);
    run_mc(1);
    run_mc(2);

    // Load-use coinciding with a start: the multi-cycle stall wins.
    id_reg1_read_i = 1; id_reg1_addr_i = 5'd8;
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd8;
    ex_mc_start_i = 1; ex_mc_cycles_i = 6'd1;
    settle();
    check("priority_mc_over_lu", stall_o, 6'b001111);
    compare_model();
    advance();
    settle();
    check("lu_in_done_state", stall_o, 6'b000111);
    compare_model();
    advance();
    clear_inputs();
    cycle();

    // Flush in the second MC_BUSY cycle aborts the operation.
    ex_mc_start_i = 1; ex_mc_cycles_i = 6'd5;
    cycle();
    cycle();
    flush_req_i = 1; flush_pc_i = 32'h0000_0100;
    settle();
    check("flush_busy_before", ex_mc_busy_o, 1);
    compare_model();
    advance();
    flush_req_i = 0; flush_pc_i = 32'hDEAD_BEEF; ex_mc_start_i = 0;
    settle();
    check("flush_o", flush_o, 1);
    check("flush_new_pc", new_pc_o, 32'h0000_0100);
    check("flush_stall", stall_o, 0);
    check("flush_no_done", ex_mc_done_o, 0);
    compare_model();
    advance();
    settle();
    check("flush_one_cycle", flush_o, 0);
    check("flush_then_idle_done", ex_mc_done_o, 0);
    check("flush_then_idle_busy", ex_mc_busy_o, 0);
    compare_model();
    advance();

    // Back-to-back flush requests keep FLUSH and reload the PC.
    flush_req_i = 1; flush_pc_i = 32'h0000_0200;
    cycle();
    flush_pc_i = 32'h0000_0300;
    settle();
    check("flush2_pc", new_pc_o, 32'h0000_0200);
    compare_model();
    advance();
    flush_req_i = 0;
    settle();
    check("flush3_o", flush_o, 1);
    check("flush3_pc", new_pc_o, 32'h0000_0300);
    compare_model();
    advance();
    cycle();

    // Asynchronous reset in the middle of MC_BUSY.
    ex_mc_start_i = 1; ex_mc_cycles_i = 6'd10;
    cycle(); cycle(); cycle();
    rst = 1; ex_mc_start_i = 0;
    #1;
    model_reset();
    check("arst_stall", stall_o, 0);
    check("arst_busy", ex_mc_busy_o, 0);
    check("arst_done", ex_mc_done_o, 0);
    check("arst_flush", flush_o, 0);
    check("arst_new_pc", new_pc_o, 0);
    check("arst_perf", stall_cycles_o, 0);
    @(negedge clk);
    rst = 0;
    advance();
    cycle();

    // Saturation: a 20-cycle operation outruns the 4-bit counter.
    ex_mc_start_i = 1; ex_mc_cycles_i = 6'd20;
    for (int k = 0; k < 21; k++) cycle();
    ex_mc_start_i = 0;
    cycle();
    settle();
    check("perf_saturated", stall_cycles_o, PERF_MAX);
    compare_model();
    advance();

    // Clear while stalling wins over the increment.
    ex_mc_start_i = 1; ex_mc_cycles_i = 6'd4;
    cycle();
    perf_clr_i = 1;
    cycle();
    perf_clr_i = 0;
    settle();
    check("perf_clr_while_stall", stall_cycles_o, 0);
    compare_model();
    advance();
    for (int k = 0; k < 3; k++) cycle();
    clear_inputs();
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      id_reg1_read_i = 1'($urandom_range(1));
      id_reg1_addr_i = 5'($urandom_range(3));
      id_reg2_read_i = 1'($urandom_range(1));
      id_reg2_addr_i = 5'($urandom_range(3));
      ex_is_load_i   = 1'($urandom_range(1));
      ex_wreg_i      = ($urandom_range(3) != 0);
      ex_wd_i        = 5'($urandom_range(3));
      ex_mc_start_i  = ($urandom_range(9) < 3);
      ex_mc_cycles_i = MC_CNT_W'($urandom_range(6));
      flush_req_i    = ($urandom_range(19) == 0);
      flush_pc_i     = $urandom;
      perf_clr_i     = ($urandom_range(29) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the five-stage MIPS32 core. It owns the per-stage stall vector and detects load-use hazards between the decode and execute stages. It sequences multi-cycle execute operations (multiply-accumulate, divide) through a cycle counter with a start/done handshake, and issues registered pipeline flushes with a redirect PC. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MC_CNT_W, 6, width of multi-cycle length field
- PERF_W, 32, width of stall performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset (`RstEnable)
- id_reg1_read_i  in  1  decode reads operand port 1
- id_reg1_addr_i  in  5  decode port-1 register address
- id_reg2_read_i  in  1  decode reads operand port 2
- id_reg2_addr_i  in  5  decode port-2 register address
- ex_is_load_i  in  1  instruction in execute is a load
- ex_wreg_i  in  1  instruction in execute writes a register
- ex_wd_i  in  5  destination register of execute instruction
- ex_mc_start_i  in  1  execute requests a multi-cycle operation; held until ex_mc_done_o
- ex_mc_cycles_i  in  MC_CNT_W  operation length N in cycles; 0 is treated as 1
- flush_req_i  in  1  flush request, one-cycle pulse
- flush_pc_i  in  32  redirect address, sampled with flush_req_i
- perf_clr_i  in  1  synchronous clear of stall_cycles_o
- stall_o  out  6  stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- ex_mc_busy_o  out  1  multi-cycle operation in progress
- ex_mc_done_o  out  1  one-cycle completion strobe to execute
- stall_cycles_o  out  PERF_W  count of cycles with stall_o[0]=1

## Operation
- FSM states:
  - IDLE: no multi-cycle operation or flush pending.
  - MC_BUSY: multi-cycle operation counting down.
  - MC_DONE: single-cycle completion state.
  - FLUSH: single-cycle flush state.
- Load-use hazard:
  - Condition: ex_is_load_i & ex_wreg_i & ex_wd_i!=0, and ex_wd_i matches a decode address whose read flag is set.
  - Effect: stall_o=6'b000111 (pc, if, id held; execute receives a bubble).
  - Evaluated only in IDLE and MC_DONE.
- Multi-cycle sequencing:
  - IDLE with ex_mc_start_i: stall_o=6'b001111 combinationally; cnt<=max(N,1)-1; next state MC_DONE if N≤1, else MC_BUSY.
  - MC_BUSY: stall_o=6'b001111 and ex_mc_busy_o=1. If cnt==1, next state is MC_DONE; otherwise cnt decrements.
  - MC_DONE: ex_mc_done_o=1, stall_o no longer holds execute; next state IDLE. ex_mc_start_i is ignored in this state.
  - Total stalled cycles equal max(N,1), counting from the start cycle.
- Priority: if the load-use and multi-cycle conditions coincide, the multi-cycle stall value wins (it is a superset).
- Flush:
  - flush_req_i in any state: next state FLUSH, new_pc_o<=flush_pc_i, cnt cleared.
  - A multi-cycle operation in flight is aborted; no done strobe is produced.
  - FLUSH state: flush_o=1, stall_o=0; next state IDLE, or FLUSH again if flush_req_i is reasserted (new_pc_o reloads).
- Performance counter:
  - Increments on every cycle with stall_o[0]=1.
  - Saturates at all-ones.
  - perf_clr_i has priority over increment; the counter then reads 0 on the next cycle.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, stall_o=0, flush_o=0, new_pc_o=0, ex_mc_busy_o=0, ex_mc_done_o=0, stall_cycles_o=0.
- Reset mid-operation aborts everything immediately; no done strobe.
- Output timing:
  - stall_o is combinational from state and inputs; zero latency on hazard.
  - flush_o and new_pc_o are registered; they assert the cycle after flush_req_i and last exactly one cycle per request.
  - ex_mc_done_o and ex_mc_busy_o are decoded from registered state.
- Handshake: execute holds start until it sees done. A back-to-back multi-cycle operation may assert start in the IDLE cycle following MC_DONE.
- Register 0 never causes a load-use stall.

## Structure
- Add to define.v:
  - `StallBus (5:0)
  - stall encodings `StallNone, `StallLoadUse, `StallMc
  - FSM state encodings
- Reuse existing define.v macros: `RegAddrBus, `InstAddrBus, `RstEnable, `ZeroWord.
- One combinational sub-module, load_use_detect (decode addresses and execute destination in, hazard flag out). FSM, counter and perf counter stay in pipeline_ctrl.

## Test plan
- Load-use: EX load to $5, ID reads reg1=$5 with read flag set -> stall_o=6'b000111 that cycle. Same case with $0 -> stall_o=0.
- Multi-cycle N=3: start at t0 -> stall_o=6'b001111 at t0–t2; ex_mc_done_o=1 at t3 only; stall_cycles_o advances by 3.
- Short lengths: N=0 and N=1 -> one stall cycle, done on the next cycle. N=2 -> two stall cycles.
- Flush: flush_req_i in cycle 2 of MC_BUSY with flush_pc_i=32'h0000_0100 -> next cycle flush_o=1, new_pc_o=32'h100, stall_o=0, no done; then IDLE.
- Reset and counter: async rst pulse mid-MC_BUSY -> all outputs 0 immediately. Preload counter to all-ones via forced stalls -> stays saturated. perf_clr_i while stalling -> counter reads 0.
